// File: rtl/pipeline_hazard_controller_pkg.sv
// riscv_pipe_pkg: shared types and widths for the pipeline hazard controller.
package riscv_pipe_pkg;
    localparam int REG_AW = 5;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_ERROR} hz_state_t;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_if: stage register fields in, pipeline-register controls out.
interface pipeline_hazard_if
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = riscv_pipe_pkg::REG_AW
);
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_error;
    fwd_sel_t fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken,
               mem_reg_write, wb_reg_write, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_error, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt, memwait_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken,
               mem_reg_write, wb_reg_write, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_error, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/pipeline_forward_unit.sv
// pipeline_forward_unit: EX operand bypass select for one source register; x0 never bypassed.
module pipeline_forward_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = riscv_pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output fwd_sel_t          sel
);
    assign sel = (mem_reg_write && mem_rd == rs && rs != '0) ? FWD_MEM :
                 (wb_reg_write && wb_rd == rs && rs != '0) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: freeze/flush/stall sequencing and forwarding for the 5-stage pipe.
// Optional perf counters built only with HAZARD_PERF_CNT_EN defined.
module pipeline_hazard_controller
    import riscv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset,
    pipeline_hazard_if.slave hz
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    hz_state_t     state;
    logic [CW-1:0] wait_cnt;
    logic          load_use, freeze, halt, flush, stall;
    pipeline_forward_unit u_fwd_a (
        .rs(hz.ex_rs1), .mem_rd(hz.mem_rd), .wb_rd(hz.wb_rd),
        .mem_reg_write(hz.mem_reg_write), .wb_reg_write(hz.wb_reg_write), .sel(hz.fwd_a_sel)
    );
    pipeline_forward_unit u_fwd_b (
        .rs(hz.ex_rs2), .mem_rd(hz.mem_rd), .wb_rd(hz.wb_rd),
        .mem_reg_write(hz.mem_reg_write), .wb_reg_write(hz.wb_reg_write), .sel(hz.fwd_b_sel)
    );
    assign load_use = hz.ex_mem_read && hz.ex_rd != '0 &&
                      ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
    assign freeze = (state == HZ_RUN && hz.dmem_req && !hz.dmem_ready) ||
                    (state == HZ_MEM_WAIT && !hz.dmem_ready);
    assign halt  = freeze || state == HZ_ERROR;
    // A redirect discards the stalled ID instruction, so it outranks load-use.
    assign flush = !halt && hz.ex_branch_taken;
    assign stall = !halt && !hz.ex_branch_taken && load_use;
    always_comb begin
        hz.pc_en       = !halt && !stall;
        hz.if_id_en    = !halt && !stall;
        hz.id_ex_en    = !halt;
        hz.ex_mem_en   = !halt;
        hz.mem_wb_en   = !halt;
        hz.if_id_flush = flush;
        hz.id_ex_flush = flush || stall;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HZ_RUN;
            wait_cnt     <= '0;
            hz.mem_error <= 1'b0;
        end else begin
            case (state)
                HZ_RUN: if (freeze) begin
                    state    <= HZ_MEM_WAIT;
                    wait_cnt <= CW'(1);
                end
                HZ_MEM_WAIT: if (hz.dmem_ready) begin
                    state    <= HZ_RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == CW'(MEM_TIMEOUT)) begin
                    state        <= HZ_ERROR;
                    hz.mem_error <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hz.stall_cnt   <= '0;
            hz.flush_cnt   <= '0;
            hz.memwait_cnt <= '0;
        end else begin
            if (stall) hz.stall_cnt <= hz.stall_cnt + 32'd1;
            if (flush) hz.flush_cnt <= hz.flush_cnt + 32'd1;
            if (freeze) hz.memwait_cnt <= hz.memwait_cnt + 32'd1;
        end
    end
`else
    assign hz.stall_cnt   = '0;
    assign hz.flush_cnt   = '0;
    assign hz.memwait_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors, expectations queued and checked by a negedge monitor.
module tb_pipeline_hazard_controller;
    localparam int K_NONE = 0, K_STALL = 1, K_FLUSH = 2, K_MW = 3;
    typedef struct {
        logic [4:0]  en;
        logic [1:0]  fl;
        logic [1:0]  fa, fb;
        logic        err;
        logic [31:0] sc, fc, mc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   n_stall = 0, n_flush = 0, n_mw = 0;
    pipeline_hazard_if bus ();
    pipeline_hazard_controller #(.MEM_TIMEOUT(15)) dut (.clk(clk), .reset(reset), .hz(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, vectors, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            chk("pc_en", 32'(bus.pc_en), 32'(e.en[4]));
            chk("if_id_en", 32'(bus.if_id_en), 32'(e.en[3]));
            chk("id_ex_en", 32'(bus.id_ex_en), 32'(e.en[2]));
            chk("ex_mem_en", 32'(bus.ex_mem_en), 32'(e.en[1]));
            chk("mem_wb_en", 32'(bus.mem_wb_en), 32'(e.en[0]));
            chk("if_id_flush", 32'(bus.if_id_flush), 32'(e.fl[1]));
            chk("id_ex_flush", 32'(bus.id_ex_flush), 32'(e.fl[0]));
            chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(e.fa));
            chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(e.fb));
            chk("mem_error", 32'(bus.mem_error), 32'(e.err));
            chk("stall_cnt", bus.stall_cnt, e.sc);
            chk("flush_cnt", bus.flush_cnt, e.fc);
            chk("memwait_cnt", bus.memwait_cnt, e.mc);
        end
    end
    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0;
        bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    endtask
    // Counters observed in a cycle reflect only the events of earlier cycles.
    task automatic step(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic err, input int kind);
        exp_t e;
        e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err;
`ifdef HAZARD_PERF_CNT_EN
        e.sc = n_stall; e.fc = n_flush; e.mc = n_mw;
`else
        e.sc = 0; e.fc = 0; e.mc = 0;
`endif
        q.push_back(e);
        if (kind == K_STALL) n_stall++;
        if (kind == K_FLUSH) n_flush++;
        if (kind == K_MW) n_mw++;
        @(posedge clk);
        #1;
    endtask
    initial begin
        idle();
        @(posedge clk);
        #1;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        reset = 1'b0;
        bus.mem_rd = 3; bus.mem_reg_write = 1; bus.wb_rd = 3; bus.wb_reg_write = 1;
        bus.ex_rs1 = 3; bus.ex_rs2 = 4;
        step(5'b11111, 2'b00, 2'b01, 2'b00, 1'b0, K_NONE);
        bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        bus.mem_rd = 3; bus.mem_reg_write = 0; bus.wb_rd = 3; bus.ex_rs1 = 3; bus.ex_rs2 = 3;
        step(5'b11111, 2'b00, 2'b10, 2'b10, 1'b0, K_NONE);
        idle();
        bus.mem_rd = 9; bus.mem_reg_write = 1; bus.wb_rd = 9; bus.wb_reg_write = 1;
        bus.ex_rs1 = 8; bus.ex_rs2 = 9;
        step(5'b11111, 2'b00, 2'b00, 2'b01, 1'b0, K_NONE);
        idle();
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
        step(5'b00111, 2'b01, 2'b00, 2'b00, 1'b0, K_STALL);
        idle();
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_rs2 = 5;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        idle();
        bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_use_rs1 = 1;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        idle();
        bus.ex_mem_read = 1; bus.ex_rd = 7; bus.id_rs2 = 7; bus.id_use_rs2 = 1;
        step(5'b00111, 2'b01, 2'b00, 2'b00, 1'b0, K_STALL);
        bus.ex_branch_taken = 1;
        step(5'b11111, 2'b11, 2'b00, 2'b00, 1'b0, K_FLUSH);
        idle();
        bus.dmem_req = 1; bus.ex_branch_taken = 1;
        repeat (3) step(5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, K_MW);
        bus.dmem_ready = 1;
        step(5'b11111, 2'b11, 2'b00, 2'b00, 1'b0, K_FLUSH);
        idle();
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        bus.dmem_req = 1; bus.dmem_ready = 1;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        bus.dmem_ready = 0;
        repeat (16) step(5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, K_MW);
        bus.dmem_ready = 1; bus.dmem_req = 0;
        step(5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, K_NONE);
        bus.ex_rs1 = 3; bus.mem_rd = 3; bus.mem_reg_write = 1;
        step(5'b00000, 2'b00, 2'b01, 2'b00, 1'b1, K_NONE);
        idle();
        reset = 1'b1;
        n_stall = 0; n_flush = 0; n_mw = 0;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        reset = 1'b0;
        step(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, K_NONE);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
